// File: rtl/pulse_stretch_led_pkg.sv
// pulse_stretch_led_pkg: shared FSM encoding and button-path time base constants.
// Debouncers and the LED stretcher import these so they agree on one tick.
package pulse_stretch_led_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_ON   = 2'b01;
    localparam state_t ST_GAP  = 2'b10;

    localparam int DEF_TICK_DIV  = 250000;
    localparam int DEF_ON_TICKS  = 40;
    localparam int DEF_OFF_TICKS = 20;
    localparam int DEF_PEND_MAX  = 7;
    localparam int DEF_PEND_W    = 3;

endpackage

// File: rtl/pulse_stretch_led_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every TICK_DIV cycles.
// clr_i restarts the count so the next tick lands exactly TICK_DIV cycles later.
module tick_gen
    import pulse_stretch_led_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clkDB,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clkDB or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pulse_stretch_led.sv
// pulse_stretch_led: stretches button-event pulses into fixed LED flashes, queueing
// events that arrive mid-flash. PULSE_STRETCH_OVF_EN builds the sticky overflow flag.
module pulse_stretch_led
    import pulse_stretch_led_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int PEND_MAX  = DEF_PEND_MAX,
    parameter int PEND_W    = DEF_PEND_W
) (
    input  logic              clkDB,
    input  logic              rst_n,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;
    localparam logic [PH_W-1:0]   ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0]   OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PMAX     = PEND_W'(PEND_MAX);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              led_q, busy_q;
    logic              tick, clr, phase_end, pend_nz, inc, dec, drop;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clkDB  (clkDB),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .tick_o (tick)
    );

    always_comb begin
        pend_nz   = (pend_q != '0);
        phase_end = tick && (phase_q == ((state_q == ST_ON) ? ON_LAST : OFF_LAST));
        state_d   = state_q;
        inc       = 1'b0;
        dec       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A non-empty queue in IDLE is unreachable; drain it anyway.
                if (pulse_in || pend_nz) begin
                    state_d = ST_ON;
                    dec     = pend_nz;
                end
            end
            ST_ON: begin
                inc = pulse_in;
                if (phase_end) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (!phase_end) begin
                    inc = pulse_in;
                end else if (pend_nz || pulse_in) begin
                    // With an empty queue the edge pulse starts the flash itself.
                    state_d = ST_ON;
                    dec     = pend_nz;
                    inc     = pulse_in && pend_nz;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        clr     = (state_d != state_q);
        phase_d = (clr || state_q == ST_IDLE) ? '0 : phase_q + PH_W'(tick);
        drop    = inc && !dec && (pend_q == PMAX);
        pend_d  = (inc && !dec && !drop) ? pend_q + 1'b1 :
                  (dec && !inc)          ? pend_q - 1'b1 : pend_q;
    end

    always_ff @(posedge clkDB or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            led_q   <= (state_d == ST_ON);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

`ifdef PULSE_STRETCH_OVF_EN
    logic ovf_q;

    always_ff @(posedge clkDB or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_q | drop;
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign led_out = led_q;
    assign busy    = busy_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_pulse_stretch_led.sv
// tb_pulse_stretch_led: randomized and directed stimulus scored per cycle against
// a cycle-countdown reference model of the flash/queue rules.
module tb_pulse_stretch_led;

    localparam int TD = 4, ONT = 3, OFFT = 2, PMX = 3, PW = 2;
    localparam int ON_CYC = ONT * TD, OFF_CYC = OFFT * TD;

    typedef struct packed {
        logic          led;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pulse_in;
    logic          led_out, busy, overflow;
    logic [PW-1:0] pending;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // reference model: phase 0=idle 1=on 2=gap, cycles left in phase, queue depth
    int m_phase, m_left, m_pend;
    bit m_ovf;

    pulse_stretch_led #(
        .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .PEND_MAX(PMX), .PEND_W(PW)
    ) dut (
        .clkDB    (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
    endtask

    task automatic enqueue();
        if (m_pend < PMX) m_pend++;
        else m_ovf = 1'b1;
    endtask

    task automatic model_edge(input logic p);
        bit last;
        last = (m_left == 1);
        if (m_phase == 0) begin
            if (p) begin m_phase = 1; m_left = ON_CYC; end
        end else if (m_phase == 1) begin
            if (p) enqueue();
            if (last) begin m_phase = 2; m_left = OFF_CYC; end
            else m_left--;
        end else if (!last) begin
            if (p) enqueue();
            m_left--;
        end else if (m_pend > 0) begin
            if (!p) m_pend--;
            m_phase = 1; m_left = ON_CYC;
        end else if (p) begin
            m_phase = 1; m_left = ON_CYC;
        end else begin
            m_phase = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.led  = (m_phase == 1);
        e.busy = (m_phase != 0);
        e.pend = PW'(m_pend);
`ifdef PULSE_STRETCH_OVF_EN
        e.ovf  = m_ovf;
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    task automatic step(input logic p);
        @(negedge clk);
        pulse_in = p;
        @(posedge clk);
        model_edge(p);
        sb.push_back(model_out());
    endtask

    task automatic check_now(input string name, input exp_t exp);
        exp_t got;
        got = {led_out, busy, pending, overflow};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got led=%b busy=%b pend=%0d ovf=%b expected led=%b busy=%b pend=%0d ovf=%b",
                     name, got.led, got.busy, got.pend, got.ovf, exp.led, exp.busy, exp.pend, exp.ovf);
        end
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while (!(m_phase == 0 && m_pend == 0) && n < 1000) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL idle_timeout got phase=%0d expected 0", m_phase);
        end
    endtask

    task automatic goto_gap_last();
        int n;
        n = 0;
        while (!(m_phase == 2 && m_left == 1) && n < 1000) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL gap_timeout got phase=%0d left=%0d expected gap end", m_phase, m_left);
        end
    endtask

    always @(negedge clk) begin
        exp_t e, got;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {led_out, busy, pending, overflow};
            checks++;
            if (got !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL cycle t=%0t got led=%b busy=%b pend=%0d ovf=%b expected led=%b busy=%b pend=%0d ovf=%b",
                             $time, got.led, got.busy, got.pend, got.ovf, e.led, e.busy, e.pend, e.ovf);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pulse_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_now("reset_state", '0);
        @(negedge clk) rst_n = 1'b1;

        // single pulse after a quiet stretch
        repeat (9) step(1'b0);
        step(1'b1);
        run_until_idle();
        repeat (5) step(1'b0);

        // three queued events -> four flashes
        step(1'b1);
        step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        run_until_idle();

        // five events during ON -> saturation, drops
        step(1'b1);
        repeat (5) step(1'b1);
        run_until_idle();

        // pulse on the GAP-end edge with a full queue
        step(1'b1);
        repeat (3) step(1'b1);
        goto_gap_last();
        step(1'b1);
        run_until_idle();

        // pulse on the GAP-end edge with an empty queue
        step(1'b1);
        goto_gap_last();
        step(1'b1);
        run_until_idle();

        // reset mid-flash with two queued events
        step(1'b1);
        step(1'b1); step(1'b1);
        repeat (2) step(1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_now("async_reset", '0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) step(1'b0);

        // randomized traffic, occasionally bursty
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) < 25) ? 1'b1 : 1'b0);
        run_until_idle();
        repeat (5) step(1'b0);

        @(negedge clk);
        pulse_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
